// File: rtl/mc_control.sv
// mc_control: multicycle main controller for the MIPS core.
// Sequences fetch, decode, execute, memory and writeback over several cycles,
// sharing one memory port and one ALU. Traps illegal opcodes and memory
// timeouts (sticky fault) and counts retired instructions.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   opcode, funct         IR[31:26], IR[5:0]
//   alu_zero, mem_ready   ALU zero flag, memory access completes this cycle
//   pc_write .. reg_write datapath enables (forced low while rst is high)
//   iord                  memory address select (0 PC, 1 ALUOut)
//   reg_dst, mem_to_reg, ext_op, jal_en, lui_en   writeback/extension controls
//   alu_src_a, alu_src_b, alu_op, pc_source       datapath muxes and ALU op
//   fault, fault_code     sticky fault flag and cause (01 illegal, 10 timeout)
//   retired               completed-instruction counter
module mc_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             iord,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             jal_en,
  output logic             lui_en,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] FnJr    = 6'b001000;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr, StExr, StRwb,
    StExi, StIwb, StBr, StJmp, StJals, StJrs, StFault
  } state_e;

  state_e             state_q;
  logic [WaitW-1:0]   wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               fault_q;
  logic [1:0]         fault_code_q;
  logic               mem_state;
  logic               timeout_hit;
  logic               retire;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // The counter holds the number of cycles already waited; ready in the
  // cycle where it equals TIMEOUT still completes the access.
  assign timeout_hit = (TIMEOUT != 0) && mem_state && !mem_ready &&
                       (wait_q == WaitW'(TIMEOUT));
  assign retire = (state_q == StMemWb) || (state_q == StRwb) || (state_q == StIwb) ||
                  (state_q == StBr) || (state_q == StJmp) || (state_q == StJals) ||
                  (state_q == StJrs) || ((state_q == StMemWr) && mem_ready);

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign retired    = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      wait_q       <= '0;
      retired_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      // Any state change clears the counter, so each memory state starts at 0.
      if (mem_state && !mem_ready) wait_q <= wait_q + WaitW'(1);
      else                         wait_q <= '0;
      if (timeout_hit) begin
        state_q      <= StFault;
        fault_q      <= 1'b1;
        fault_code_q <= 2'b10;
      end else begin
        unique case (state_q)
          StFetch:   if (mem_ready) state_q <= StDecode;
          StDecode: begin
            case (opcode)
              OpRtype:      state_q <= (funct == FnJr) ? StJrs : StExr;
              OpLw, OpSw:   state_q <= StMemAddr;
              OpBeq, OpBne: state_q <= StBr;
              OpJ:          state_q <= StJmp;
              OpJal:        state_q <= StJals;
              OpAddi, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: state_q <= StExi;
              default: begin
                state_q      <= StFault;
                fault_q      <= 1'b1;
                fault_code_q <= 2'b01;
              end
            endcase
          end
          StMemAddr: state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
          StMemRd:   if (mem_ready) state_q <= StMemWb;
          StMemWr:   if (mem_ready) state_q <= StFetch;
          StExr:     state_q <= StRwb;
          StExi:     state_q <= StIwb;
          StMemWb, StRwb, StIwb, StBr, StJmp, StJals, StJrs: state_q <= StFetch;
          StFault:   state_q <= StFault;
          default:   state_q <= StFetch;
        endcase
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b1;
    jal_en     = 1'b0;
    lui_en     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_source  = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode:  alu_src_b = 2'b11;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExr: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StExi: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OpSlti:  alu_op = 3'b110;
          OpSltiu: alu_op = 3'b111;
          OpAndi: begin
            alu_op = 3'b011;
            ext_op = 1'b0;
          end
          OpOri: begin
            alu_op = 3'b100;
            ext_op = 1'b0;
          end
          OpXori: begin
            alu_op = 3'b101;
            ext_op = 1'b0;
          end
          OpLui:   lui_en = 1'b1;
          default: alu_op = 3'b000;
        endcase
      end
      StIwb: begin
        reg_write = 1'b1;
        lui_en    = (opcode == OpLui);
      end
      StBr: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        pc_write  = (opcode == OpBeq) ? alu_zero : !alu_zero;
      end
      StJmp: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StJals: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        reg_write = 1'b1;
        jal_en    = 1'b1;
      end
      StJrs: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control (TIMEOUT=4). Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'b0;
  logic [5:0]  funct = 6'b0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, iord;
  logic        reg_dst, mem_to_reg, ext_op, jal_en, lui_en, alu_src_a;
  logic [1:0]  alu_src_b, pc_source, fault_code;
  logic [2:0]  alu_op;
  logic        fault;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  mc_control #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .ext_op(ext_op), .jal_en(jal_en), .lui_en(lui_en),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .fault(fault), .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, mem_read, mem_write, reg_write}
  logic [4:0] en;
  assign en = {pc_write, ir_write, mem_read, mem_write, reg_write};

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b001000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (en !== 5'b00000) begin
      errors++; $display("FAIL reset_enables: got %b want 00000", en);
    end
    checks++;
    if ({fault, fault_code} !== 3'b000 || retired !== 32'd0) begin
      errors++; $display("FAIL reset_state: fault=%b code=%b retired=%0d want 0/00/0",
                         fault, fault_code, retired);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [31:0] r0;
    r0 = retired;
    opcode = 6'b001000; mem_ready = 1'b1;
    #1;
    checks++;
    if (en !== 5'b11100 || alu_src_b !== 2'b01 || iord !== 1'b0 || alu_src_a !== 1'b0) begin
      errors++; $display("FAIL addi_fetch: en=%b b=%b iord=%b want 11100 01 0", en, alu_src_b, iord);
    end
    @(negedge clk); #1;
    checks++;
    if (en !== 5'b00000 || alu_src_b !== 2'b11 || alu_op !== 3'b000) begin
      errors++; $display("FAIL addi_decode: en=%b b=%b op=%b want 00000 11 000", en, alu_src_b, alu_op);
    end
    @(negedge clk); #1;
    checks++;
    if (en !== 5'b00000 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 3'b000 ||
        ext_op !== 1'b1) begin
      errors++; $display("FAIL addi_exi: en=%b a=%b b=%b op=%b ext=%b want 00000 1 10 000 1",
                         en, alu_src_a, alu_src_b, alu_op, ext_op);
    end
    @(negedge clk); #1;
    checks++;
    if (en !== 5'b00001 || reg_dst !== 1'b0) begin
      errors++; $display("FAIL addi_iwb: en=%b reg_dst=%b want 00001 0", en, reg_dst);
    end
    @(negedge clk); #1;
    checks++;
    if (retired !== r0 + 32'd1) begin
      errors++; $display("FAIL addi_retired: got %0d want %0d", retired, r0 + 32'd1);
    end
  endtask

  task automatic test_lw_wait();
    logic [31:0] r0;
    logic [7:0]  rdy;
    logic [4:0]  exp_en [8];
    logic [7:0]  exp_iord;
    int          ir_pulses;
    r0 = retired;
    rdy = 8'b1101_1100;        // bit i = mem_ready in cycle i
    exp_iord = 8'b0110_0000;
    exp_en = '{5'b00100, 5'b00100, 5'b11100, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00001};
    ir_pulses = 0;
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      if (ir_write === 1'b1) ir_pulses++;
      checks++;
      if (en !== exp_en[i] || iord !== exp_iord[i]) begin
        errors++; $display("FAIL lw_cycle%0d: en=%b iord=%b want %b %b",
                           i, en, iord, exp_en[i], exp_iord[i]);
      end
      if (i == 7) begin
        checks++;
        if (mem_to_reg !== 1'b1 || retired !== r0) begin
          errors++; $display("FAIL lw_memwb: mem_to_reg=%b retired=%0d want 1 %0d",
                             mem_to_reg, retired, r0);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ir_pulses !== 1 || retired !== r0 + 32'd1 || mem_read !== 1'b1) begin
      errors++; $display("FAIL lw_done: ir_pulses=%0d retired=%0d fetch=%b want 1 %0d 1",
                         ir_pulses, retired, mem_read, r0 + 32'd1);
    end
  endtask

  // Three-cycle branch/jump; checks the third cycle and the retire.
  task automatic run3(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [4:0] want_en, input logic [1:0] want_src,
                      input logic want_jal);
    logic [31:0] r0;
    r0 = retired;
    opcode = op; funct = fn; alu_zero = z; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (en !== want_en || pc_source !== want_src || jal_en !== want_jal) begin
      errors++; $display("FAIL %s: en=%b pc_source=%b jal_en=%b want %b %b %b",
                         name, en, pc_source, jal_en, want_en, want_src, want_jal);
    end
    @(negedge clk); #1;
    checks++;
    if (retired !== r0 + 32'd1) begin
      errors++; $display("FAIL %s_retired: got %0d want %0d", name, retired, r0 + 32'd1);
    end
  endtask

  task automatic test_branch_jump();
    run3("beq_taken", 6'b000100, 6'd0, 1'b1, 5'b10000, 2'b01, 1'b0);
    run3("bne_not_taken", 6'b000101, 6'd0, 1'b1, 5'b00000, 2'b01, 1'b0);
    run3("bne_taken", 6'b000101, 6'd0, 1'b0, 5'b10000, 2'b01, 1'b0);
    run3("jal", 6'b000011, 6'd0, 1'b0, 5'b10001, 2'b10, 1'b1);
    run3("jr", 6'b000000, 6'b001000, 1'b0, 5'b10000, 2'b11, 1'b0);
  endtask

  task automatic test_alu_ops();
    // ORI
    opcode = 6'b001101; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ext_op !== 1'b0 || alu_op !== 3'b100) begin
      errors++; $display("FAIL ori_exi: ext=%b op=%b want 0 100", ext_op, alu_op);
    end
    repeat (2) @(negedge clk);
    // R-type add
    opcode = 6'b000000; funct = 6'b100000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (alu_op !== 3'b010 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || en !== 5'b00000) begin
      errors++; $display("FAIL rtype_exr: op=%b a=%b b=%b en=%b want 010 1 00 00000",
                         alu_op, alu_src_a, alu_src_b, en);
    end
    @(negedge clk); #1;
    checks++;
    if (en !== 5'b00001 || reg_dst !== 1'b1) begin
      errors++; $display("FAIL rtype_rwb: en=%b reg_dst=%b want 00001 1", en, reg_dst);
    end
    @(negedge clk);
    // LUI
    opcode = 6'b001111;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (lui_en !== 1'b1 || en !== 5'b00000) begin
      errors++; $display("FAIL lui_exi: lui_en=%b en=%b want 1 00000", lui_en, en);
    end
    @(negedge clk); #1;
    checks++;
    if (lui_en !== 1'b1 || en !== 5'b00001) begin
      errors++; $display("FAIL lui_iwb: lui_en=%b en=%b want 1 00001", lui_en, en);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    int bad;
    opcode = 6'b111111; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      if (en !== 5'b00000 || fault !== 1'b1 || fault_code !== 2'b01) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL illegal_fault_hold: bad_cycles=%0d want 0 (code=%b)", bad, fault_code);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (en !== 5'b00000) begin
      errors++; $display("FAIL illegal_rst_enables: en=%b want 00000", en);
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || retired !== 32'd0 || en !== 5'b00100) begin
      errors++; $display("FAIL illegal_after_rst: fault=%b code=%b retired=%0d en=%b want 0 00 0 00100",
                         fault, fault_code, retired, en);
    end
  endtask

  task automatic test_timeout();
    int waits;
    logic [31:0] r0;
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    waits = 0;
    #1;
    while (mem_write === 1'b1 && fault === 1'b0 && waits < 10) begin
      waits++;
      @(negedge clk); #1;
    end
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || mem_write !== 1'b0 || waits < 4) begin
      errors++; $display("FAIL timeout_fault: fault=%b code=%b mem_write=%b waits=%0d want 1 10 0 >=4",
                         fault, fault_code, mem_write, waits);
    end
    @(negedge clk);
    do_reset();
    // Ready on the fourth MEMWR cycle completes normally.
    r0 = retired;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    waits = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (mem_write === 1'b1) waits++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (fault !== 1'b0 || retired !== r0 + 32'd1 || waits !== 4 || mem_read !== 1'b1) begin
      errors++; $display("FAIL timeout_ready_wins: fault=%b retired=%0d wr_cycles=%0d fetch=%b want 0 %0d 4 1",
                         fault, retired, waits, mem_read, r0 + 32'd1);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch_jump();
    test_alu_ops();
    test_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main controller for the MIPS core: a Moore/Mealy FSM that replaces the single-cycle opcode decoder and sequences fetch, decode, execute, memory and writeback over several cycles using one shared memory port and one ALU. It sits between the instruction register and the multicycle datapath, handshakes with memory through `mem_ready`, traps illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- `TIMEOUT`, 16: max wait cycles per memory access before a fault; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]. `funct` in 6: IR[5:0].
- `alu_zero` in 1: ALU zero flag. `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` out 1: datapath enables.
- `iord` out 1: 0 selects PC as the memory address, 1 selects ALUOut.
- `reg_dst`, `mem_to_reg`, `ext_op`, `jal_en`, `lui_en` out 1: writeback and extension controls. `ext_op`=1 selects sign extension, 0 selects zero extension.
- `alu_src_a` out 1: 0 selects PC, 1 selects rs.
- `alu_src_b` out 2: 00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2.
- `alu_op` out 3: 000 add, 001 sub, 010 funct decode, 011 and, 100 or, 101 xor, 110 slt, 111 sltu.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- `fault` out 1: sticky fault. `fault_code` out 2: 01 illegal opcode, 10 memory timeout.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXR, RWB, EXI, IWB, BR, JMP, JALS, JRS, FAULT.
- Unlisted outputs are 0. Defaults are `ext_op`=1 and `alu_op`=000.
- FETCH: `iord`=0, `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `pc_source`=00.
  - Stays in FETCH until `mem_ready`.
  - In the ready cycle it asserts `ir_write`=1 and `pc_write`=1, then goes to DECODE.
- DECODE: `alu_src_b`=11, `alu_op`=add, which precomputes the branch target into ALUOut. Next state by opcode:
  - 000000 with `funct`=001000 goes to JRS; any other 000000 goes to EXR.
  - 100011 or 101011 go to MEMADDR.
  - 000100 or 000101 go to BR.
  - 000010 goes to JMP; 000011 goes to JALS.
  - 001000, 001010, 001011, 001100, 001101, 001110 and 001111 go to EXI.
  - Any other opcode goes to FAULT with code 01.
- MEMADDR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: `iord`=1, `mem_read`=1; waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- MEMWR: `iord`=1, `mem_write`=1; waits for `mem_ready`.
- EXR: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. RWB: `reg_write`=1, `reg_dst`=1.
- EXI: `alu_src_a`=1, `alu_src_b`=10. By opcode:
  - ADDI: add.
  - SLTI: slt.
  - SLTIU: sltu, `ext_op`=1.
  - ANDI, ORI, XORI: and, or, xor, each with `ext_op`=0.
  - LUI: `lui_en`=1.
- IWB: `reg_write`=1, `reg_dst`=0; `lui_en` is held for LUI.
- BR: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_source`=01.
  - `pc_write` = `alu_zero` for BEQ, !`alu_zero` for BNE.
- JMP: `pc_write`=1, `pc_source`=10.
- JALS: same as JMP, plus `reg_write`=1 and `jal_en`=1 (writes $31 with the PC already incremented).
- JRS: `pc_write`=1, `pc_source`=11.
- MEMWB, MEMWR (on ready), RWB, IWB, BR, JMP, JALS and JRS each retire the instruction: `retired` increments by 1 (wrapping modulo 2^CNT_W) and the next state is FETCH.
- FAULT: every enable is 0 and `fault`=1. It holds until `rst`.

## Timing
- The state register is updated on `clk`. Outputs are decoded from state; the only Mealy terms are `mem_ready`, `alu_zero` and `opcode`.
- Reset:
  - Sets the state to FETCH, `retired`=0, `fault`=0, `fault_code`=00 and the wait counter to 0.
  - While `rst`=1 every enable (`pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) is forced to 0.
  - A reset mid-instruction abandons the instruction without retiring it.
- Latency with zero memory wait, counted in cycles including FETCH:
  - BEQ, BNE, J, JAL, JR: 3.
  - R-type, I-ALU, LUI, SW: 4.
  - LW: 5.
  - Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - Cleared on entry to each memory state.
  - Increments each cycle `mem_ready` is 0.
  - When it reaches TIMEOUT, the next state is FAULT with code 10.
  - If `mem_ready`=1 in the same cycle, ready wins.
  - With TIMEOUT=0 the controller waits indefinitely.
- `fault_code` latches on FAULT entry and is never overwritten until reset.

## Test plan
- Reset, then ADDI with `mem_ready` tied to 1: the sequence is FETCH, DECODE, EXI, IWB; `reg_write`=1 in cycle 4; `retired`=1; `ext_op`=1.
- LW with `mem_ready` low 2 cycles in FETCH and 1 cycle in MEMRD: the instruction completes in 8 cycles; `mem_read`=1 throughout the waits; `ir_write` pulses exactly once.
- BEQ with `alu_zero`=1 gives `pc_write`=1 and `pc_source`=01 in cycle 3. BNE with `alu_zero`=1 gives `pc_write`=0. Both increment `retired`.
- ORI: `ext_op`=0, `alu_op`=100. JAL: `jal_en`=`reg_write`=`pc_write`=1 and `pc_source`=10. JR (`funct`=001000): `pc_source`=11 and `reg_write`=0.
- `opcode`=111111: FAULT after DECODE with `fault_code`=01; all enables stay 0 for 20 cycles; `rst` returns the controller to FETCH with `retired`=0.
- TIMEOUT=4 with `mem_ready` held 0 in MEMWR: FAULT with code 10 and `mem_write` dropped. Repeat with ready arriving on the 4th wait cycle: no fault and the instruction retires.
